// File: rtl/if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_pkg                                                     |
// | Brief   : Shared defaults, fetch state encoding and PC alignment.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package if_pkg;

  localparam logic [31:0] C_NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_hold_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_hold_buf                                                |
// | Brief   : One-entry (insn, pc) buffer for a word returned under stall|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_insn,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_insn;
  logic [31:0] r_pc;

  // Clear wins so a flush in the same cycle never leaves a stale entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_insn  <= C_NOP_INSN;
      r_pc    <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_insn  <= i_insn;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_insn  = r_insn;
  assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_stage                                                   |
// | Brief   : Instruction fetch + IF/ID register with stall/redirect.    |
// |           Define IF_MISALIGN_TRAP_EN to add the fetch_misalign flag. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter logic [31:0] NOP_INSN = C_NOP_INSN
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir2,
  output logic [31:0] pc2,
  output logic        valid2
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_drain_addr;
  logic [31:0]  w_redirect_target;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic         w_buf_valid;
  logic [31:0]  w_buf_insn;
  logic [31:0]  w_buf_pc;

  assign w_redirect_target = word_align(redirect_pc);

  // DRAIN keeps presenting the abandoned address until its response arrives.
  assign imem_req  = (r_state == FETCH) || (r_state == DRAIN);
  assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

  assign w_buf_load  = !redirect && (r_state == FETCH) && imem_ready && stall;
  assign w_buf_clear = redirect || ((r_state == HOLD) && !stall);

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_insn  (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_buf_valid),
    .o_insn  (w_buf_insn),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      ir2          <= NOP_INSN;
      pc2          <= 32'h0;
      valid2       <= 1'b0;
    end else if (redirect) begin
      ir2    <= NOP_INSN;
      valid2 <= 1'b0;
      r_pc   <= w_redirect_target;
      case (r_state)
        FETCH: begin
          if (!imem_ready) begin
            r_state      <= DRAIN;
            r_drain_addr <= r_pc;
          end
        end
        DRAIN:   r_state <= DRAIN;
        default: r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            r_pc <= r_pc + 32'd4;
            if (stall) begin
              r_state <= HOLD;
            end else begin
              ir2    <= imem_rdata;
              pc2    <= r_pc;
              valid2 <= 1'b1;
            end
          end else if (!stall) begin
            ir2    <= NOP_INSN;
            valid2 <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ir2     <= w_buf_insn;
            pc2     <= w_buf_pc;
            valid2  <= w_buf_valid;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_misalign <= 1'b0;
    else        fetch_misalign <= redirect && (redirect_pc[1:0] != 2'b00);
  end
`endif

endmodule
`default_nettype wire
